// File: rtl/mgmt_data_channel_target.sv
// rtl/mgmt_data_channel_target.sv - management data channel target: request decode, local bus access, framed response
package ltpi_pkg;
    typedef enum logic [3:0] {
        link_lost_st,
        link_detect_st,
        link_speed_st,
        link_cfg_st,
        link_accept_st,
        operational_st
    } link_state_t;

    localparam logic [3:0] frame_length = 4'd15;

    localparam logic [7:0] READ_REQ   = 8'h01;
    localparam logic [7:0] WRITE_REQ  = 8'h02;
    localparam logic [7:0] READ_COMP  = 8'h03;
    localparam logic [7:0] WRITE_COMP = 8'h04;
    localparam logic [7:0] CRC_ERROR  = 8'h05;

    typedef struct packed {
        logic [7:0]  command;
        logic [3:0]  tag;
        logic [3:0]  byte_en;
        logic [31:0] address;
        logic [31:0] data;
        logic        operation_status;
    } Data_channel_payload_t;
endpackage

module mgmt_data_channel_target
    import ltpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  data_channel_rst,
    input  Data_channel_payload_t payload_i,
    input  logic                  payload_i_valid,
    input  logic                  frm_crc_error,
    input  link_state_t           local_link_state,
    input  logic [3:0]            tx_frm_offset,
    input  logic [31:0]           operational_frm_sent,
    output logic                  bus_req_valid,
    output logic                  bus_req_write,
    output logic [31:0]           bus_req_address,
    output logic [3:0]            bus_req_byte_en,
    output logic [31:0]           bus_req_wdata,
    input  logic                  bus_req_ready,
    input  logic                  bus_rsp_valid,
    input  logic                  bus_rsp_error,
    input  logic [31:0]           bus_rsp_rdata,
    output Data_channel_payload_t res_payload_o,
    output logic                  res_payload_o_valid,
    output logic [15:0]           drop_cnt
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, BUS_REQ, BUS_WAIT, RSP_ALIGN, RSP_SEND, RSP_HOLD
    } state_t;

    state_t                state, state_next;
    logic                  rst;
    logic                  valid_q, edge_q, crc_d;
    Data_channel_payload_t payload_d, rsp_q;
    logic [CW-1:0]         tmo_cnt;
    logic                  off_seen;
    logic [31:0]           sent_q;
    logic                  is_rw, is_write, timeout, link_up, at_boundary;
    logic [31:0]           frames_since;
    logic [7:0]            comp_cmd;

    assign rst          = !reset_n || data_channel_rst;
    assign is_rw        = (payload_d.command == READ_REQ) || (payload_d.command == WRITE_REQ);
    // rsp_q keeps the original request command until the bus access completes
    assign is_write     = (rsp_q.command == WRITE_REQ);
    assign comp_cmd     = is_write ? WRITE_COMP : READ_COMP;
    assign timeout      = (tmo_cnt >= CW'(TIMEOUT_CYCLES - 1));
    assign link_up      = (local_link_state == operational_st);
    assign at_boundary  = (tx_frm_offset == frame_length);
    assign frames_since = operational_frm_sent - sent_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (edge_q) state_next = (!crc_d && is_rw) ? BUS_REQ : RSP_ALIGN;
            BUS_REQ:   if (bus_req_ready) state_next = BUS_WAIT;
                       else if (timeout) state_next = RSP_ALIGN;
            BUS_WAIT:  if (bus_rsp_valid || timeout) state_next = RSP_ALIGN;
            RSP_ALIGN: if (!link_up) state_next = IDLE;
                       else if (at_boundary) state_next = RSP_SEND;
            RSP_SEND:  if (!link_up) state_next = IDLE;
                       else if (off_seen && at_boundary) state_next = RSP_HOLD;
            RSP_HOLD:  if (!link_up || frames_since > 32'd2) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q             <= 1'b0;
            edge_q              <= 1'b0;
            crc_d               <= 1'b0;
            payload_d           <= '0;
            rsp_q               <= '0;
            tmo_cnt             <= '0;
            off_seen            <= 1'b0;
            sent_q              <= '0;
            drop_cnt            <= '0;
            bus_req_valid       <= 1'b0;
            bus_req_write       <= 1'b0;
            bus_req_address     <= '0;
            bus_req_byte_en     <= '0;
            bus_req_wdata       <= '0;
            res_payload_o       <= '0;
            res_payload_o_valid <= 1'b0;
        end else begin
            valid_q   <= payload_i_valid;
            edge_q    <= payload_i_valid && !valid_q;
            payload_d <= payload_i;
            crc_d     <= frm_crc_error;

            if (edge_q && state != IDLE && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;

            case (state)
                IDLE: if (edge_q) begin
                    // Non-bus responses echo the request with error status set
                    rsp_q                  <= payload_d;
                    rsp_q.operation_status <= 1'b1;
                    if (crc_d) rsp_q.command <= CRC_ERROR;
                    if (!crc_d && is_rw) begin
                        bus_req_valid   <= 1'b1;
                        bus_req_write   <= (payload_d.command == WRITE_REQ);
                        bus_req_address <= payload_d.address;
                        bus_req_byte_en <= payload_d.byte_en;
                        bus_req_wdata   <= payload_d.data;
                        tmo_cnt         <= '0;
                    end
                end
                BUS_REQ, BUS_WAIT: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    if (state == BUS_REQ && bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                    end else if (state == BUS_WAIT && bus_rsp_valid) begin
                        rsp_q.command          <= comp_cmd;
                        rsp_q.data             <= is_write ? rsp_q.data : bus_rsp_rdata;
                        rsp_q.operation_status <= bus_rsp_error;
                    end else if (timeout) begin
                        bus_req_valid          <= 1'b0;
                        rsp_q.command          <= comp_cmd;
                        rsp_q.data             <= '0;
                        rsp_q.operation_status <= 1'b1;
                    end
                end
                RSP_ALIGN: if (link_up && at_boundary) begin
                    res_payload_o       <= rsp_q;
                    res_payload_o_valid <= 1'b1;
                    sent_q              <= operational_frm_sent;
                    off_seen            <= 1'b0;
                end
                RSP_SEND: begin
                    if (!link_up) res_payload_o_valid <= 1'b0;
                    else if (!at_boundary) off_seen <= 1'b1;
                    else if (off_seen) res_payload_o_valid <= 1'b0;
                end
                default: res_payload_o_valid <= 1'b0;
            endcase
        end
    end
endmodule

// File: doc/mgmt_data_channel_target.md
MGMT_DATA_CHANNEL_TARGET -- requirements
Module: mgmt_data_channel_target

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: maximum clk cycles from bus request issue to bus response.
REQ-002 Types Data_channel_payload_t, link_state_t, frame_length, and the command codes READ_REQ, WRITE_REQ, READ_COMP, WRITE_COMP and CRC_ERROR all come from ltpi_pkg.
REQ-003 Port clk  in  1  single clock for all logic.
REQ-004 Port reset_n  in  1  reset; synchronous, active-low.
REQ-005 Port data_channel_rst  in  1  synchronous active-high soft reset; same effect as reset_n=0.
REQ-006 Port payload_i  in  Data_channel_payload_t  received request payload from phy.
REQ-007 Port payload_i_valid  in  1  level; rising edge marks a new request.
REQ-008 Port frm_crc_error  in  1  CRC error flag of the received frame.
REQ-009 Port local_link_state  in  link_state_t  current link state.
REQ-010 Port tx_frm_offset  in  4  transmit frame position.
REQ-011 Port operational_frm_sent  in  32  count of operational frames sent.
REQ-012 Port bus_req_valid/bus_req_write/bus_req_address[31:0]/bus_req_byte_en[3:0]/bus_req_wdata[31:0]  out  local bus request.
REQ-013 Port bus_req_ready  in  1  local bus accepts the request.
REQ-014 Port bus_rsp_valid/bus_rsp_error/bus_rsp_rdata[31:0]  in  local bus response; single-cycle pulse.
REQ-015 Port res_payload_o  out  Data_channel_payload_t  response payload to phy.
REQ-016 Port res_payload_o_valid  out  1  response payload valid.
REQ-017 Port drop_cnt  out  16  saturating count of dropped requests.

Function
REQ-018 Request detect: payload_i_valid rises (registered edge); capture payload_i and frm_crc_error, each delayed one cycle, into a request latch.
REQ-019 FSM states: IDLE, BUS_REQ, BUS_WAIT, RSP_ALIGN, RSP_SEND, RSP_HOLD.
REQ-020 IDLE, edge seen, no CRC error, command READ_REQ or WRITE_REQ: go to BUS_REQ.
  - Command otherwise: go to RSP_ALIGN; no bus access.
REQ-021 BUS_REQ: drive bus_req_valid=1; bus_req_write=1 only for WRITE_REQ; address, byte_en and wdata come from the latch.
  - Hold all request fields stable until bus_req_ready=1, then go to BUS_WAIT.
REQ-022 BUS_WAIT: on bus_rsp_valid, latch bus_rsp_rdata and bus_rsp_error, then go to RSP_ALIGN.
REQ-023 Timeout counter starts on entry to BUS_REQ.
  - Reaching TIMEOUT_CYCLES in BUS_REQ or BUS_WAIT: deassert bus_req_valid, set status=1 and data=0, go to RSP_ALIGN.
REQ-024 Response fields: tag and address are echoed from the request.
  - Command is READ_COMP or WRITE_COMP.
  - Data is rdata for a read and the write data echoed for a write.
  - byte_en is echoed.
  - operation_status equals bus_rsp_error.
REQ-025 CRC-errored request: command=CRC_ERROR, operation_status=1, other fields echoed.
REQ-026 Unknown command: command echoed, operation_status=1.
REQ-027 RSP_ALIGN, link operational and tx_frm_offset==frame_length: load res_payload_o, set res_payload_o_valid=1, latch operational_frm_sent, go to RSP_SEND.
REQ-028 RSP_SEND: once tx_frm_offset!=frame_length and then ==frame_length again, clear res_payload_o_valid and go to RSP_HOLD.
REQ-029 RSP_HOLD: return to IDLE when operational_frm_sent > latch+2, using 32-bit unsigned compare with wrap.
REQ-030 A request edge in any state other than IDLE is dropped; drop_cnt increments and saturates at 0xFFFF.
REQ-031 local_link_state != operational_st in RSP_ALIGN, RSP_SEND or RSP_HOLD: clear res_payload_o_valid, discard the response, go to IDLE.
  - Bus states are not affected by link state.
REQ-032 Edge and bus response in the same cycle while in BUS_WAIT: the response is consumed and the edge counts as a drop.

Reset
REQ-033 reset_n=0 or data_channel_rst=1 at a clk edge sets the following, with priority over all other logic:
  - FSM=IDLE.
  - bus_req_valid=0, bus_req_write=0, bus_req_address=0, bus_req_byte_en=0, bus_req_wdata=0.
  - res_payload_o='0, res_payload_o_valid=0.
  - drop_cnt=0, timeout counter=0, edge detector=0.
REQ-034 A reset asserted mid-transaction abandons the transaction; no response is sent after reset deasserts.

Verification
REQ-035 READ_REQ, tag=0x5, addr=0x100, bus returns rdata=0xDEADBEEF after 3 cycles -> one response at the next frame boundary: READ_COMP, tag 0x5, data 0xDEADBEEF, status 0.
REQ-036 WRITE_REQ with byte_en=0x3 and bus_req_ready delayed 5 cycles -> request fields held stable for 5 cycles; WRITE_COMP, status 0.
REQ-037 Request with frm_crc_error=1 -> no bus_req_valid; response CRC_ERROR, status 1.
REQ-038 Bus never responds, TIMEOUT_CYCLES=16 -> bus_req_valid drops at cycle 16; response status 1, data 0.
REQ-039 Two requests 2 cycles apart -> one bus access; drop_cnt=1.
REQ-040 Link leaves operational_st during RSP_SEND -> res_payload_o_valid=0 next cycle, FSM IDLE; separately, reset_n=0 in BUS_WAIT -> all outputs at reset values next cycle.
